// File: rtl/id_stage_pipe_if.sv
// Decode-stage bundle: fetch handshake, writeback port, EX hazard info and the
// registered ID/EX payload. The stage itself connects through the slave modport.
interface id_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int INST_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [INST_W-1:0] iIR;
    logic              iValid;
    logic              oReady;
    logic              iR2Select;
    logic [1:0]        iSignExtCtrl;
    logic              iFlush;
    logic              rf_we;
    logic [REG_AW-1:0] WAddr;
    logic [DATA_W-1:0] WData;
    logic              iExLoad;
    logic [REG_AW-1:0] iExRd;
    logic              oValid;
    logic              iReady;
    logic [REG_AW-1:0] woRdsAddr;
    logic [REG_AW-1:0] woRs1Addr;
    logic [REG_AW-1:0] woRs2Addr;
    logic [DATA_W-1:0] woOP1;
    logic [DATA_W-1:0] woOP2;
    logic [DATA_W-1:0] woIMM;
    logic [CNT_W-1:0]  oStallCnt;

    modport slave (
        input  iIR, iValid, iR2Select, iSignExtCtrl, iFlush,
               rf_we, WAddr, WData, iExLoad, iExRd, iReady,
        output oReady, oValid, woRdsAddr, woRs1Addr, woRs2Addr,
               woOP1, woOP2, woIMM, oStallCnt
    );

    modport master (
        output iIR, iValid, iR2Select, iSignExtCtrl, iFlush,
               rf_we, WAddr, WData, iExLoad, iExRd, iReady,
        input  oReady, oValid, woRdsAddr, woRs1Addr, woRs2Addr,
               woOP1, woOP2, woIMM, oStallCnt
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage: register file with write-first bypass, immediate extension and
// an ID/EX register with valid/ready handshake, flush and load-use stalling.
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int INST_W = 32,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 17,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           reset,
    id_stage_pipe_if.slave bus
);
    localparam int NREGS = 2**REG_AW;

    logic [DATA_W-1:0] r_rf [NREGS];
    logic              r_valid;
    logic [REG_AW-1:0] r_rd, r_rs1, r_rs2;
    logic [DATA_W-1:0] r_op1, r_op2, r_imm;
    logic [CNT_W-1:0]  r_cnt;

    logic [REG_AW-1:0] w_rd, w_rs1, w_rs2f, w_ra2;
    logic [IMM_W-1:0]  w_imm_raw;
    logic [DATA_W-1:0] w_imm, w_op1, w_op2;
    logic              w_wr, w_hz, w_adv;
    logic              w_unused;

    assign w_rd      = bus.iIR[22 +: REG_AW];
    assign w_rs1     = bus.iIR[17 +: REG_AW];
    assign w_rs2f    = bus.iIR[11 +: REG_AW];
    assign w_ra2     = bus.iR2Select ? w_rd : w_rs2f;
    assign w_imm_raw = bus.iIR[IMM_W-1:0];
    assign w_unused  = ^bus.iIR[INST_W-1:27];

    // r0 is never written, so it stays at its reset value of zero
    assign w_wr = bus.rf_we && (bus.WAddr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (w_wr) begin
            r_rf[bus.WAddr] <= bus.WData;
        end
    end

    always_comb begin
        w_op1 = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
        w_op2 = (w_ra2 == '0) ? '0 : r_rf[w_ra2];
        if (w_wr && bus.WAddr == w_rs1) w_op1 = bus.WData;
        if (w_wr && bus.WAddr == w_ra2) w_op2 = bus.WData;
    end

    always_comb begin
        w_imm = '0;
        case (bus.iSignExtCtrl)
            2'b00:   w_imm = DATA_W'(w_imm_raw);
            2'b01:   w_imm = DATA_W'($signed(w_imm_raw));
            2'b10:   w_imm = DATA_W'($signed(w_imm_raw[15:0]));
            default: w_imm = DATA_W'({w_imm_raw[15:0], 16'b0});
        endcase
    end

    assign w_hz  = bus.iValid && bus.iExLoad && (bus.iExRd != '0) &&
                   ((bus.iExRd == w_rs1) || (bus.iExRd == w_ra2));
    assign w_adv = !r_valid || bus.iReady;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_imm   <= '0;
            r_cnt   <= '0;
        end else if (bus.iFlush) begin
            r_valid <= 1'b0;
        end else if (w_adv && w_hz) begin
            // bubble: fetch keeps presenting the same instruction
            r_valid <= 1'b0;
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_adv && bus.iValid) begin
            r_valid <= 1'b1;
            r_rd    <= w_rd;
            r_rs1   <= w_rs1;
            r_rs2   <= w_ra2;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_imm   <= w_imm;
        end else if (w_adv) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.oReady    = w_adv && !w_hz;
    assign bus.oValid    = r_valid;
    assign bus.woRdsAddr = r_rd;
    assign bus.woRs1Addr = r_rs1;
    assign bus.woRs2Addr = r_rs2;
    assign bus.woOP1     = r_op1;
    assign bus.woOP2     = r_op2;
    assign bus.woIMM     = r_imm;
    assign bus.oStallCnt = r_cnt;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed sequences, an immediate-mode vector table and
// random traffic, all checked against a behavioural model of the decode stage.
module tb_id_stage_pipe;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    id_stage_pipe_if bus ();
    id_stage_pipe_if #(.CNT_W(3)) bus_s ();

    id_stage_pipe dut (.clk(clk), .reset(reset), .bus(bus));
    id_stage_pipe #(.CNT_W(3)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    // narrow-counter copy sees identical stimulus, so saturation is reachable quickly
    assign bus_s.iIR          = bus.iIR;
    assign bus_s.iValid       = bus.iValid;
    assign bus_s.iR2Select    = bus.iR2Select;
    assign bus_s.iSignExtCtrl = bus.iSignExtCtrl;
    assign bus_s.iFlush       = bus.iFlush;
    assign bus_s.rf_we        = bus.rf_we;
    assign bus_s.WAddr        = bus.WAddr;
    assign bus_s.WData        = bus.WData;
    assign bus_s.iExLoad      = bus.iExLoad;
    assign bus_s.iExRd        = bus.iExRd;
    assign bus_s.iReady       = bus.iReady;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_op1, m_op2, m_imm;
    int          m_cnt, m_cnt_s;

    typedef struct {
        logic [31:0] ir;
        logic [1:0]  ctrl;
        logic [31:0] exp_imm;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [16:0] low);
        return {5'b0, rd, rs1, low};
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] ir, input logic [1:0] c);
        int v, lo;
        v  = int'(ir[16:0]);
        lo = int'(ir[15:0]);
        case (c)
            2'd0:    return v;
            2'd1:    return (v >= 65536) ? v - 131072 : v;
            2'd2:    return (lo >= 32768) ? lo - 65536 : lo;
            default: return lo * 65536;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus.rf_we && bus.WAddr == a) return bus.WData;
        return m_rf[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_valid = 1'b0;
        m_rd = '0; m_rs1 = '0; m_rs2 = '0;
        m_op1 = '0; m_op2 = '0; m_imm = '0;
        m_cnt = 0; m_cnt_s = 0;
    endtask

    task automatic check_outputs();
        chk("oValid",    bus.oValid,    m_valid);
        chk("oValid_s",  bus_s.oValid,  m_valid);
        chk("woRdsAddr", bus.woRdsAddr, m_rd);
        chk("woRs1Addr", bus.woRs1Addr, m_rs1);
        chk("woRs2Addr", bus.woRs2Addr, m_rs2);
        chk("woOP1",     bus.woOP1,     m_op1);
        chk("woOP2",     bus.woOP2,     m_op2);
        chk("woIMM",     bus.woIMM,     m_imm);
        chk("oStallCnt", bus.oStallCnt, m_cnt);
        chk("oStallCnt_s", bus_s.oStallCnt, m_cnt_s);
    endtask

    // one clock: check oReady, advance the model with current inputs, check registers
    task automatic tick();
        logic [4:0]  rdst, rs1, ra2;
        logic        hz, adv;
        logic [31:0] o1, o2;
        #1;
        rdst = bus.iIR[26:22];
        rs1  = bus.iIR[21:17];
        ra2  = bus.iR2Select ? rdst : bus.iIR[15:11];
        hz   = bus.iValid && bus.iExLoad && bus.iExRd != 0 &&
               (bus.iExRd == rs1 || bus.iExRd == ra2);
        adv  = !m_valid || bus.iReady;
        chk("oReady",   bus.oReady,   adv && !hz);
        chk("oReady_s", bus_s.oReady, adv && !hz);
        o1 = m_read(rs1);
        o2 = m_read(ra2);
        if (bus.iFlush) m_valid = 1'b0;
        else if (adv && hz) begin
            m_valid = 1'b0;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 7) m_cnt_s++;
        end else if (adv && bus.iValid) begin
            m_valid = 1'b1;
            m_rd = rdst; m_rs1 = rs1; m_rs2 = ra2;
            m_op1 = o1; m_op2 = o2;
            m_imm = m_ext(bus.iIR, bus.iSignExtCtrl);
        end else if (adv) m_valid = 1'b0;
        if (bus.rf_we && bus.WAddr != 0) m_rf[bus.WAddr] = bus.WData;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        tbl[0] = '{mk(0, 0, 17'h18000), 2'b00, 32'h0001_8000};
        tbl[1] = '{mk(0, 0, 17'h18000), 2'b01, 32'hFFFF_8000};
        tbl[2] = '{mk(0, 0, 17'h18000), 2'b10, 32'hFFFF_8000};
        tbl[3] = '{mk(0, 0, 17'h18000), 2'b11, 32'h8000_0000};
        tbl[4] = '{mk(0, 0, 17'h07FFF), 2'b01, 32'h0000_7FFF};
        tbl[5] = '{mk(0, 0, 17'h1FFFF), 2'b00, 32'h0001_FFFF};
        tbl[6] = '{mk(0, 0, 17'h07FFF), 2'b10, 32'h0000_7FFF};
        tbl[7] = '{mk(0, 0, 17'h0ABCD), 2'b11, 32'hABCD_0000};

        bus.iIR = '0; bus.iValid = 0; bus.iR2Select = 0; bus.iSignExtCtrl = 0;
        bus.iFlush = 0; bus.rf_we = 0; bus.WAddr = 0; bus.WData = 0;
        bus.iExLoad = 0; bus.iExRd = 0; bus.iReady = 1;
        m_reset();
        #12;
        check_outputs();
        chk("reset_oReady", bus.oReady, 1'b1);
        reset = 1'b1;

        // writeback then read through the register file
        bus.rf_we = 1; bus.WAddr = 3; bus.WData = 32'h1234_5678;
        tick();
        bus.rf_we = 0; bus.iIR = mk(0, 3, 17'h0); bus.iValid = 1;
        tick();
        chk("t1_valid", bus.oValid, 1'b1);
        chk("t1_op1", bus.woOP1, 32'h1234_5678);
        chk("t1_op2", bus.woOP2, 32'h0);

        // same-cycle bypass, and r0 neither bypassed nor written
        bus.rf_we = 1; bus.WAddr = 7; bus.WData = 32'hDEAD_BEEF; bus.iIR = mk(0, 7, 17'h0);
        tick();
        chk("t2_bypass", bus.woOP1, 32'hDEAD_BEEF);
        bus.WAddr = 0; bus.WData = 32'hCAFE_F00D; bus.iIR = mk(0, 0, 17'h0);
        tick();
        chk("t2_r0_bypass", bus.woOP1, 32'h0);
        bus.rf_we = 0; bus.iIR = mk(0, 0, 17'h0);
        tick();
        chk("t2_r0_read", bus.woOP1, 32'h0);
        bus.iIR = mk(0, 7, 17'h0);
        tick();
        chk("t2_r7_read", bus.woOP1, 32'hDEAD_BEEF);

        for (int i = 0; i < 8; i++) begin
            bus.iIR = tbl[i].ir; bus.iSignExtCtrl = tbl[i].ctrl;
            tick();
            chk($sformatf("imm_vec%0d", i), bus.woIMM, tbl[i].exp_imm);
        end
        bus.iSignExtCtrl = 0;

        // load-use stall on Rs1, then on Rs2, until the small counter saturates
        bus.iExLoad = 1; bus.iExRd = 5; bus.iIR = mk(0, 5, 17'h0);
        #1;
        chk("t4_oReady_stall", bus.oReady, 1'b0);
        tick();
        chk("t4_bubble", bus.oValid, 1'b0);
        chk("t4_cnt1", bus.oStallCnt, 32'd1);
        bus.iIR = mk(0, 1, 17'h02800);
        for (int i = 0; i < 8; i++) tick();
        chk("t4_cnt9", bus.oStallCnt, 32'd9);
        chk("t4_cnt_sat", bus_s.oStallCnt, 32'd7);
        bus.iExLoad = 0;
        tick();
        chk("t4_accept", bus.oValid, 1'b1);
        bus.iExLoad = 1; bus.iExRd = 0; bus.iIR = mk(0, 0, 17'h0);
        #1;
        chk("t4_rd0_nohz", bus.oReady, 1'b1);
        tick();
        bus.iExLoad = 0;

        // back-pressure holds the payload, flush wins, then Rst selection
        bus.iIR = mk(4, 3, 17'h0);
        tick();
        bus.iReady = 0; bus.iIR = mk(2, 7, 17'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_ready", bus.oReady, 1'b0);
            chk("t5_hold_op1", bus.woOP1, 32'h1234_5678);
            chk("t5_hold_rd", bus.woRdsAddr, 32'd4);
            chk("t5_hold_valid", bus.oValid, 1'b1);
        end
        bus.iFlush = 1;
        tick();
        chk("t5_flush", bus.oValid, 1'b0);
        bus.iFlush = 0; bus.iR2Select = 1; bus.iIR = mk(9, 0, 17'h0); bus.iReady = 1;
        tick();
        chk("t5_rst_sel", bus.woRs2Addr, 32'd9);
        bus.iR2Select = 0;

        // asynchronous reset mid-operation
        #3;
        reset = 1'b0;
        #1;
        m_reset();
        check_outputs();
        #1;
        reset = 1'b1;
        bus.iIR = mk(0, 3, 17'h0); bus.iValid = 1;
        tick();
        chk("rst_rf_cleared", bus.woOP1, 32'h0);

        for (int i = 0; i < 1500; i++) begin
            bus.iIR = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                bus.iIR[26:22] = 5'($urandom_range(0, 3));
                bus.iIR[21:17] = 5'($urandom_range(0, 3));
                bus.iIR[15:11] = 5'($urandom_range(0, 3));
            end
            bus.iValid       = ($urandom_range(0, 3) != 0);
            bus.iR2Select    = 1'($urandom_range(0, 1));
            bus.iSignExtCtrl = 2'($urandom_range(0, 3));
            bus.iFlush       = ($urandom_range(0, 9) == 0);
            bus.rf_we        = 1'($urandom_range(0, 1));
            bus.WAddr        = 5'($urandom_range(0, 7));
            bus.WData        = $urandom;
            bus.iExLoad      = ($urandom_range(0, 2) == 0);
            bus.iExRd        = 5'($urandom_range(0, 3));
            bus.iReady       = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
